// File: rtl/sevenseg_scan_driver.sv
// Multiplexed scan driver for a common-anode seven-segment display.
// Double-buffers the BCD digits so each frame is shown from one consistent snapshot.
module sevenseg_scan_driver #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned NUM_DIGITS  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_mask_i,
    input  logic                    lz_blank_i,
    input  logic                    enable_i,
    input  logic                    update_i,
    output logic                    update_ack_o,
    output logic                    frame_o,
    output logic [3:0]              decimal_o,
    output logic                    is_dp_on_o,
    output logic [NUM_DIGITS-1:0]   anode_o
);

    localparam int unsigned TICK_CYCLES = CLK_FREQ_HZ / SCAN_HZ;
    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] stage_dig_q, stage_dig_d;
    logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [3:0]              decimal_q, decimal_d;
    logic                    dp_on_q, dp_on_d;
    logic                    ack_q, ack_d;
    logic                    frame_q, frame_d;

    logic                    tick, wrap;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_run;
    logic [3:0]              sel_dig;
    logic                    sel_dp;
    logic                    sel_blank;

    always_comb begin
        tick = (cnt_q == CNT_LAST);
        wrap = tick && (idx_q == IDX_LAST);

        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        // Commit reads the pre-edge staging, so an update landing on the wrap waits a frame.
        stage_dig_d  = update_i ? digits_i  : stage_dig_q;
        stage_dp_d   = update_i ? dp_mask_i : stage_dp_q;
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q || update_i;
        if (wrap && pending_q) begin
            shadow_dig_d = stage_dig_q;
            shadow_dp_d  = stage_dp_q;
            pending_d    = update_i;
        end
        ack_d   = wrap && pending_q;
        frame_d = wrap;

        // Walk from the most significant digit down while the run of blank zeros holds.
        zero_run = lz_blank_i;
        blank    = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            zero_run = zero_run && (shadow_dig_q[4*(NUM_DIGITS-1-j) +: 4] == 4'd0)
                                && !shadow_dp_q[NUM_DIGITS-1-j];
            blank[NUM_DIGITS-1-j] = zero_run && ((NUM_DIGITS - 1 - j) != 0);
        end

        sel_dig   = 4'hF;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                sel_dig   = shadow_dig_q[4*k +: 4];
                sel_dp    = shadow_dp_q[k];
                sel_blank = blank[k];
            end
        end

        anode_d   = '1;
        decimal_d = 4'hF;
        dp_on_d   = 1'b0;
        if (enable_i) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                anode_d[k] = (idx_q != IW'(k));
            end
            decimal_d = sel_blank ? 4'hF : sel_dig;
            dp_on_d   = sel_dp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            stage_dig_q  <= '1;
            stage_dp_q   <= '0;
            shadow_dig_q <= '1;
            shadow_dp_q  <= '0;
            anode_q      <= '1;
            decimal_q    <= 4'hF;
            dp_on_q      <= 1'b0;
            ack_q        <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            stage_dig_q  <= stage_dig_d;
            stage_dp_q   <= stage_dp_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            anode_q      <= anode_d;
            decimal_q    <= decimal_d;
            dp_on_q      <= dp_on_d;
            ack_q        <= ack_d;
            frame_q      <= frame_d;
        end
    end

    assign anode_o      = anode_q;
    assign decimal_o    = decimal_q;
    assign is_dp_on_o   = dp_on_q;
    assign update_ack_o = ack_q;
    assign frame_o      = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver with 4 clocks per slot and 4 digits.
// Expected outputs are queued per cycle by the stimulus and popped by a separate monitor.
module tb_sevenseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp_mask = '0;
    logic        lz_blank = 1'b0;
    logic        enable = 1'b1;
    logic        update = 1'b0;
    logic        update_ack;
    logic        frame;
    logic [3:0]  decimal;
    logic        is_dp_on;
    logic [3:0]  anode;

    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        int unsigned cyc;
        string       tag;
        logic [3:0]  an;
        logic [3:0]  dec;
        logic        dp;
        logic        ack;
        logic        fr;
    } exp_t;

    exp_t q[$];

    sevenseg_scan_driver #(
        .CLK_FREQ_HZ(400),
        .SCAN_HZ    (100),
        .NUM_DIGITS (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .digits_i    (digits),
        .dp_mask_i   (dp_mask),
        .lz_blank_i  (lz_blank),
        .enable_i    (enable),
        .update_i    (update),
        .update_ack_o(update_ack),
        .frame_o     (frame),
        .decimal_o   (decimal),
        .is_dp_on_o  (is_dp_on),
        .anode_o     (anode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int unsigned c, input string tag, input logic [3:0] an,
                        input logic [3:0] dec, input logic dp, input logic ack, input logic fr);
        exp_t e;
        e.cyc = c; e.tag = tag; e.an = an; e.dec = dec; e.dp = dp; e.ack = ack; e.fr = fr;
        q.push_back(e);
    endtask

    // One frame of output cycles r+16m+1 .. r+16m+16; the last carries the frame/ack pulse.
    task automatic push_frame(input int unsigned r, input int unsigned m, input string tag,
                              input logic [15:0] slots, input logic [3:0] dps, input logic ack_last,
                              input int unsigned dark_lo, input int unsigned dark_hi,
                              input int unsigned stop);
        for (int unsigned t = 1; t <= 16; t++) begin
            int unsigned c;
            int unsigned i;
            logic [3:0]  an;
            logic        last;
            c    = r + 16*m + t;
            i    = (t - 1) / 4;
            last = (t == 16);
            if (c > stop) break;
            an = 4'b1111;
            an[i] = 1'b0;
            if (c >= dark_lo && c <= dark_hi)
                push(c, tag, 4'b1111, 4'hF, 1'b0, last && ack_last, last);
            else
                push(c, tag, an, slots[4*i +: 4], dps[i], last && ack_last, last);
        end
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive_upd(input int unsigned c, input logic [15:0] d, input logic [3:0] dp);
        wait_cyc(c);
        digits  = d;
        dp_mask = dp;
        update  = 1'b1;
        wait_cyc(c + 1);
        update  = 1'b0;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL %s cyc=%0d: expectation not checked in its cycle", q[0].tag, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (anode !== e.an || decimal !== e.dec || is_dp_on !== e.dp ||
                update_ack !== e.ack || frame !== e.fr) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got an=%b dec=%h dp=%b ack=%b fr=%b, want an=%b dec=%h dp=%b ack=%b fr=%b",
                         e.tag, cyc, anode, decimal, is_dp_on, update_ack, frame,
                         e.an, e.dec, e.dp, e.ack, e.fr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned c = 1; c <= 3; c++) push(c, "reset", 4'b1111, 4'hF, 1'b0, 1'b0, 1'b0);
        push_frame(3, 0, "scan_blank", 16'hFFFF, 4'b0000, 1'b0, 0, 0, 9999);
        push_frame(3, 1, "scan_blank", 16'hFFFF, 4'b0000, 1'b1, 0, 0, 9999);
        wait_cyc(3);
        rst = 1'b0;

        drive_upd(24, 16'h1234, 4'b0100);
        push_frame(3, 2, "update_1234", 16'h1234, 4'b0100, 1'b0, 0, 0, 9999);
        push_frame(3, 3, "tearfree_hold", 16'h1234, 4'b0100, 1'b1, 0, 0, 9999);

        drive_upd(53, 16'h1111, 4'b0000);
        drive_upd(58, 16'h2222, 4'b0000);
        push_frame(3, 4, "tearfree_2222", 16'h2222, 4'b0000, 1'b0, 0, 0, 9999);
        push_frame(3, 5, "lz_nonzero", 16'h2222, 4'b0000, 1'b1, 0, 0, 9999);

        wait_cyc(85);
        lz_blank = 1'b1;
        drive_upd(85, 16'h0050, 4'b0000);
        push_frame(3, 6, "lz_0050", 16'hFF50, 4'b0000, 1'b1, 0, 0, 9999);

        drive_upd(101, 16'h0050, 4'b0100);
        push_frame(3, 7, "lz_0050_dp", 16'hF050, 4'b0100, 1'b1, 0, 0, 9999);

        drive_upd(120, 16'h0007, 4'b0001);
        push_frame(3, 8, "collide_old", 16'hFFF7, 4'b0001, 1'b1, 0, 0, 9999);
        push_frame(3, 9, "collide_new", 16'hF890, 4'b0000, 1'b0, 0, 0, 9999);
        drive_upd(130, 16'h0890, 4'b0000);

        wait_cyc(163);
        lz_blank = 1'b0;
        push_frame(3, 10, "enable_off", 16'h0890, 4'b0000, 1'b0, 170, 179, 9999);
        wait_cyc(169);
        enable = 1'b0;
        push_frame(3, 11, "enable_resume", 16'h0890, 4'b0000, 1'b0, 0, 0, 190);
        wait_cyc(179);
        enable = 1'b1;

        drive_upd(185, 16'h1111, 4'b0000);
        wait_cyc(190);
        rst = 1'b1;
        push(191, "reset_mid", 4'b1111, 4'hF, 1'b0, 1'b0, 1'b0);
        push(192, "reset_mid", 4'b1111, 4'hF, 1'b0, 1'b0, 1'b0);
        push_frame(192, 0, "post_reset", 16'hFFFF, 4'b0000, 1'b0, 0, 0, 9999);
        push_frame(192, 1, "post_reset", 16'hFFFF, 4'b0000, 1'b0, 0, 0, 9999);
        wait_cyc(192);
        rst = 1'b0;

        wait_cyc(226);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
